lab7_imem_loader: RTL and testbench
===================================

Name: lab7_imem_loader

Overview:
- Write-side counterpart of the fetch/decode path.
- Accepts instruction fields (format, opcode, funct3, funct7, rd, rs1, rs2, imm) over a valid/ready handshake and encodes them into 32-bit RV32 words.
- Writes the words sequentially into the instruction RAM at byte addresses 0, 4, 8, …, matching the fetch PC stride.
- Holds the CPU in reset while loading and releases it when done.

Parameters:
- ADDR_W, 8: byte-address width, same as the PC.
- DEPTH, 64: instruction words of capacity. Constraint: DEPTH*4 <= 2**ADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load at address 0
- finish  in  1  one-cycle pulse; ends the load early
- in_valid  in  1  instruction fields valid
- in_ready  out  1  loader can accept fields this cycle
- fmt  in  2  00=R, 01=I, 10=S, 11=illegal
- opcode  in  7  instruction bits [6:0]
- funct3  in  3  instruction bits [14:12]
- funct7  in  7  R-type bits [31:25]
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- imm  in  12  I/S immediate
- we  out  1  RAM write strobe
- waddr  out  ADDR_W  RAM byte address
- wdata  out  32  encoded instruction word
- count  out  $clog2(DEPTH)+1  words written so far
- hold_cpu  out  1  keeps the PC/CPU in reset
- load_done  out  1  load complete
- err  out  1  sticky illegal-format flag

Behaviour:
Reset (synchronous, clk rising edge with reset=1):
- State goes to IDLE.
- we=0, waddr=0, wdata=0, count=0, in_ready=0, load_done=0, err=0.
- hold_cpu=1.
- Reset asserted mid-load aborts immediately with the same values; no partial write is issued.

FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE: hold_cpu=1. On start, go to LOAD with count=0 and err=0.
- LOAD: in_ready=1 unless count==DEPTH.
  - On in_valid && in_ready: register the encoded word into wdata, set waddr=count*4, go to WRITE.
- WRITE: exactly one cycle. we=1 and in_ready=0. Then count+=1.
  - Go to DONE if a finish was latched or the new count==DEPTH.
  - Otherwise return to LOAD.
- DONE: load_done=1, hold_cpu=0, in_ready=0, we=0. On start, go to LOAD with count=0, err=0, load_done=0, hold_cpu=1.

Throughput and latency:
- One word per 2 cycles.
- A field accepted on edge N is written (we=1) in the cycle after edge N.

Encoding (combinational from the inputs, registered at acceptance):
- R: {funct7, rs2, rs1, funct3, rd, opcode}
- I: {imm[11:0], rs1, funct3, rd, opcode}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
- fmt=11: writes NOP 0x00000013 and sets err=1 (sticky until the next start or reset).

Boundaries and simultaneous events:
- finish in LOAD with no accept: go to DONE next cycle.
- finish in the same cycle as an accept: the word is still written, then DONE.
- finish during WRITE: latched, takes effect after the write.
- start in LOAD or WRITE: ignored.
- finish in IDLE or DONE: ignored.
- Full (count==DEPTH): in_ready=0. Writing the last word always ends in DONE, with no wrap-around.
- in_valid while in_ready=0: no effect. Fields need not be held stable.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: adds a 32-bit output csum.
  - csum=0 on reset and on start.
  - On each we cycle, csum <= csum ^ wdata.
  - Value is held in DONE.
- Undefined: no csum port, no checksum logic.

Decomposition:
- Shared package lab7_pkg holds:
  - FMT_R=2'b00, FMT_I=2'b01, FMT_S=2'b10, FMT_BAD=2'b11.
  - NOP_WORD=32'h00000013.
  - State encodings: IDLE=0, LOAD=1, WRITE=2, DONE=3.
- One sub-module, lab7_encoder: combinational fields → 32-bit word, plus an illegal flag. It is the exact inverse of the existing field decoder.
- FSM, counter and address generation stay in the top module.

Test Plan:
- start, then I-type fields (opcode 0x13, funct3 0, rd 1, rs1 0, imm 5) → next cycle we=1, waddr=0x00, wdata=0x00500093; count=1 afterwards.
- Continue with R-type add (opcode 0x33, rd 3, rs1 1, rs2 2, funct7 0) and then S-type sw (opcode 0x23, funct3 2, rs1 1, rs2 2, imm 8), then finish → writes 0x002081B3 @0x04 and 0x0020A423 @0x08; load_done=1, hold_cpu=0, count=3.
- Keep in_valid=1 continuously from start → we pulses on alternate cycles, DEPTH words written to addresses 0..252; in_ready=0 once count==64; DONE reached without finish.
- fmt=11 with any fields → wdata=0x00000013 written and err=1; err clears on the next start.
- reset asserted during WRITE → next cycle we=0, count=0, hold_cpu=1, state IDLE; in_valid ignored until start.
- finish in the same cycle as an accept → that word is written, then DONE. With LOADER_CHECKSUM_EN defined, after the 3-word load in the second scenario, csum=0x00500093^0x002081B3^0x0020A423.

Source files
------------

// File: rtl/lab7_pkg.sv
// Shared definitions for the instruction-memory loader: field formats, NOP word,
// loader state encoding and the instruction-field payload.
package lab7_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_S   = 2'b10;
  localparam logic [1:0] FMT_BAD = 2'b11;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Instruction fields as presented on the loader input handshake
  typedef struct packed {
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } instr_fields_t;

endpackage

// File: rtl/lab7_encoder.sv
// Combinational RV32 encoder: packs R/I/S fields into a 32-bit word (inverse of
// the field decoder); illegal formats yield a NOP and raise illegal_c.
module lab7_encoder
  import lab7_pkg::*;
(
  input  instr_fields_t       fields,
  output logic [WORD_W-1:0]   word_c,
  output logic                illegal_c
);

  always_comb begin
    word_c    = NOP_WORD;
    illegal_c = 1'b0;
    case (fields.fmt)
      FMT_R: word_c = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                       fields.rd, fields.opcode};
      FMT_I: word_c = {fields.imm, fields.rs1, fields.funct3, fields.rd,
                       fields.opcode};
      FMT_S: word_c = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                       fields.imm[4:0], fields.opcode};
      default: begin
        word_c    = NOP_WORD;
        illegal_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lab7_imem_loader.sv
// Instruction-RAM loader: accepts encoded fields one word per two cycles, writes
// them at byte stride 4 and holds the CPU in reset until done.
// Optional LOADER_CHECKSUM_EN adds a running XOR checksum output csum.
module lab7_imem_loader
  import lab7_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    finish,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              fmt,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic [4:0]              rd,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  input  logic [11:0]             imm,
  output logic                    we,
  output logic [ADDR_W-1:0]       waddr,
  output logic [WORD_W-1:0]       wdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    hold_cpu,
  output logic                    load_done,
  output logic                    err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]       csum
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_t              state;
  logic                fin_q;
  instr_fields_t       fields;
  logic [WORD_W-1:0]   enc_word_c;
  logic                enc_illegal_c;
  logic                accept_c;
  logic                start_ok_c;
  logic [CNT_W-1:0]    count_inc_c;

  assign fields      = {fmt, opcode, funct3, funct7, rd, rs1, rs2, imm};
  assign accept_c    = (state == LOAD) && in_valid && in_ready;
  assign start_ok_c  = ((state == IDLE) || (state == DONE)) && start;
  assign count_inc_c = count + CNT_W'(1);

  lab7_encoder u_encoder (
    .fields    (fields),
    .word_c    (enc_word_c),
    .illegal_c (enc_illegal_c)
  );

  // Load sequencer; every output is registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fin_q     <= 1'b0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      load_done <= 1'b0;
      err       <= 1'b0;
      hold_cpu  <= 1'b1;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            fin_q     <= 1'b0;
            count     <= '0;
            err       <= 1'b0;
            load_done <= 1'b0;
            hold_cpu  <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        LOAD: begin
          if (accept_c) begin
            state    <= WRITE;
            wdata    <= enc_word_c;
            waddr    <= ADDR_W'({count, 2'b00});
            err      <= err | enc_illegal_c;
            we       <= 1'b1;
            in_ready <= 1'b0;
            fin_q    <= finish;
          end else if (finish) begin
            state     <= DONE;
            load_done <= 1'b1;
            hold_cpu  <= 1'b0;
            in_ready  <= 1'b0;
          end
        end
        WRITE: begin
          count <= count_inc_c;
          fin_q <= 1'b0;
          // A finish seen at accept or during the write ends the load here
          if (fin_q || finish || (count_inc_c == FULL)) begin
            state     <= DONE;
            load_done <= 1'b1;
            hold_cpu  <= 1'b0;
            in_ready  <= 1'b0;
          end else begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every word written during the current load
  always_ff @(posedge clk) begin
    if (reset || start_ok_c) begin
      csum <= '0;
    end else if (we) begin
      csum <= csum ^ wdata;
    end
  end
`endif

endmodule

// File: tb/tb_lab7_imem_loader.sv
// Directed bench for lab7_imem_loader: transaction-level reference model checked
// every cycle, plus literal expectations from hand-encoded RV32 words.
module tb_lab7_imem_loader;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset, start, finish, in_valid;
  logic [1:0]  fmt;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm;
  logic        in_ready, we, hold_cpu, load_done, err;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic [6:0]  count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  lab7_imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .we(we), .waddr(waddr), .wdata(wdata), .count(count),
    .hold_cpu(hold_cpu), .load_done(load_done), .err(err)
`ifdef LOADER_CHECKSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [1:0] f, input logic [6:0] op,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [4:0] d, input logic [4:0] s1,
                                      input logic [4:0] s2, input logic [11:0] im);
    case (f)
      2'b00:   return {f7, s2, s1, f3, d, op};
      2'b01:   return {im, s1, f3, d, op};
      2'b10:   return {im[11:5], s2, s1, f3, im[4:0], op};
      default: return 32'h0000_0013;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: loading session, pending write, finished flag, word count
  bit          m_loading = 0, m_pending = 0, m_done = 0, m_fin = 0, m_err = 0, m_we = 0;
  int          m_count = 0;
  logic [7:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0, m_csum = '0;

  always @(posedge clk) begin : model
    bit l, p, d, f, e, w;
    int c;
    logic [7:0] a;
    logic [31:0] dw, cs;
    l = m_loading; p = m_pending; d = m_done; f = m_fin; e = m_err;
    c = m_count; a = m_waddr; dw = m_wdata; cs = m_csum; w = 1'b0;
    if (reset) begin
      l = 0; p = 0; d = 0; f = 0; e = 0; c = 0; a = '0; dw = '0; cs = '0;
    end else if (p) begin
      c = c + 1;
      cs = cs ^ dw;
      p = 0;
      if (finish) f = 1;
      if (f || c == DEPTH) begin l = 0; d = 1; f = 0; end
    end else if (l) begin
      if (in_valid && c < DEPTH) begin
        dw = enc(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);
        a  = 8'(c * 4);
        e  = e | (fmt == 2'b11);
        p  = 1; w = 1; f = finish;
      end else if (finish) begin
        l = 0; d = 1;
      end
    end else if (start) begin
      l = 1; d = 0; c = 0; e = 0; cs = '0; f = 0;
    end
    m_loading <= l; m_pending <= p; m_done <= d; m_fin <= f; m_err <= e;
    m_count <= c; m_waddr <= a; m_wdata <= dw; m_csum <= cs; m_we <= w;
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  32'(in_ready),  32'(m_loading && !m_pending && (m_count < DEPTH)));
      chk("we",        32'(we),        32'(m_we));
      chk("waddr",     32'(waddr),     32'(m_waddr));
      chk("wdata",     wdata,          m_wdata);
      chk("count",     32'(count),     32'(m_count));
      chk("hold_cpu",  32'(hold_cpu),  32'(!m_done));
      chk("load_done", 32'(load_done), 32'(m_done));
      chk("err",       32'(err),       32'(m_err));
`ifdef LOADER_CHECKSUM_EN
      chk("csum",      csum,           m_csum);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic set_fields(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [11:0] im);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  // Present fields until accepted; returns in the write cycle of that word
  task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [11:0] im, input bit fin);
    bit acc = 1'b0;
    set_fields(f, op, f3, f7, d, s1, s2, im);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        finish = fin;
        acc = 1'b1;
        step();
        break;
      end
      step();
    end
    in_valid = 1'b0;
    finish = 1'b0;
    set_fields(2'($urandom), 7'($urandom), 3'($urandom), 7'($urandom),
               5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom));
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never high within 20 cycles");
    end
  endtask

  initial begin
    bit reached;
    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    set_fields('0, '0, '0, '0, '0, '0, '0, '0);
    step();
    chk_en = 1'b1;
    step();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_hold", 32'(hold_cpu), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    step();

    // I-type addi x1, x0, 5
    pulse_start();
    chk("s1_ready", 32'(in_ready), 32'd1);
    send(2'b01, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 12'd5, 1'b0);
    chk("s1_we", 32'(we), 32'd1);
    chk("s1_waddr", 32'(waddr), 32'h00);
    chk("s1_wdata", wdata, 32'h0050_0093);
    step();
    chk("s1_count", 32'(count), 32'd1);

    // R-type add, S-type sw, finish during the last write
    send(2'b00, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);
    chk("s2_wdata_r", wdata, 32'h0020_81B3);
    chk("s2_waddr_r", 32'(waddr), 32'h04);
    step();
    send(2'b10, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 12'd8, 1'b0);
    chk("s2_wdata_s", wdata, 32'h0020_A423);
    chk("s2_waddr_s", 32'(waddr), 32'h08);
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk("s2_done", 32'(load_done), 32'd1);
    chk("s2_hold", 32'(hold_cpu), 32'd0);
    chk("s2_count", 32'(count), 32'd3);
`ifdef LOADER_CHECKSUM_EN
    chk("s2_csum", csum, 32'h0050_2503);
`endif
    finish = 1'b1;
    step();
    finish = 1'b0;
    step();

    // Finish in LOAD with no accept
    pulse_start();
    chk("s3_cleared", 32'(load_done), 32'd0);
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk("s3_done", 32'(load_done), 32'd1);
    chk("s3_count", 32'(count), 32'd0);

    // Illegal format writes NOP and sets sticky err
    pulse_start();
    send(2'b11, 7'h7F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 12'hFFF, 1'b0);
    chk("s4_nop", wdata, 32'h0000_0013);
    step();
    chk("s4_err", 32'(err), 32'd1);
    send(2'b01, 7'h13, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 12'hFFF, 1'b0);
    chk("s4_wdata_neg", wdata, 32'hFFF1_0113);
    step();
    chk("s4_err_sticky", 32'(err), 32'd1);
    finish = 1'b1;
    step();
    finish = 1'b0;
    pulse_start();
    chk("s4_err_clr", 32'(err), 32'd0);

    // Finish in the same cycle as an accept
    send(2'b01, 7'h13, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 12'd1, 1'b1);
    chk("s5_we", 32'(we), 32'd1);
    step();
    chk("s5_done", 32'(load_done), 32'd1);
    chk("s5_count", 32'(count), 32'd1);

    // Reset during WRITE aborts; valid is ignored until start
    pulse_start();
    send(2'b00, 7'h33, 3'd0, 7'h20, 5'd5, 5'd6, 5'd7, 12'd0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s6_we", 32'(we), 32'd0);
    chk("s6_count", 32'(count), 32'd0);
    chk("s6_hold", 32'(hold_cpu), 32'd1);
    in_valid = 1'b1;
    repeat (4) step();
    in_valid = 1'b0;
    chk("s6_idle_count", 32'(count), 32'd0);

    // Continuous valid fills all DEPTH words; stray start mid-load ignored
    pulse_start();
    reached = 1'b0;
    for (int c = 0; c < 300; c++) begin
      set_fields(2'(c % 3), 7'(c), 3'(c), 7'(c * 3), 5'(c), 5'(c + 1), 5'(c + 2), 12'(c * 7));
      in_valid = 1'b1;
      start = (c == 10);
      step();
      if (load_done) begin
        reached = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("s7_reached", 32'(reached), 32'd1);
    chk("s7_count", 32'(count), 32'd64);
    chk("s7_last_addr", 32'(waddr), 32'hFC);
    repeat (3) step();
    in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
